// File: rtl/output_layer_argmax_tnndirect.sv
// Output layer of the direct ternary network: serial per-class score
// accumulation over hard-wired ternary weights, then serial argmax.
// Result is presented with a sticky done flag until reset.

// Per-class signed score accumulator.
module output_layer_argmax_tnndirect_cls #(
  parameter int                              HIDDEN_CNT = 4,
  parameter int                              CLASS_CNT  = 3,
  parameter int                              C          = 0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] WEIGHTS    = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] MASK       = '0,
  parameter int                              SW         = 4,
  parameter int                              HCW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [HCW-1:0]       i_hcnt,
  input  logic                 i_h,
  output logic signed [SW-1:0] o_score,
  output logic signed [SW-1:0] o_score_nxt
);
  // This class's column of the weight/mask matrices, indexed by hidden index
  logic [HIDDEN_CNT-1:0] w_wcol;
  logic [HIDDEN_CNT-1:0] w_mcol;
  logic                  w_w;
  logic                  w_m;
  logic signed [SW-1:0]  w_contrib;
  logic signed [SW-1:0]  r_score;

  for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_col
    assign w_wcol[h] = WEIGHTS[h*CLASS_CNT+C];
    assign w_mcol[h] = MASK[h*CLASS_CNT+C];
  end

  assign w_w = w_wcol[i_hcnt];
  assign w_m = w_mcol[i_hcnt];

  // Ternary contribution: 0 when masked, +1 on sign agreement, else -1
  always_comb begin
    w_contrib = '0;
    if (w_m) w_contrib = (i_h ~^ w_w) ? SW'(1) : {SW{1'b1}};
  end

  assign o_score_nxt = r_score + w_contrib;
  assign o_score     = r_score;

  // Score register: cleared at run start, accumulates during ACC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_score <= '0;
    else if (i_clr) r_score <= '0;
    else if (i_en)  r_score <= o_score_nxt;
  end
endmodule

module output_layer_argmax_tnndirect #(
  parameter int                              HIDDEN_CNT = 4,
  parameter int                              CLASS_CNT  = 3,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] WEIGHTS    = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] MASK       = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [HIDDEN_CNT-1:0]        hidden,
  output logic [$clog2(CLASS_CNT)-1:0] class_out,
  output logic                         done
);
  // Score width is derived; |score| <= HIDDEN_CNT so it never overflows
  localparam int SW  = $clog2(HIDDEN_CNT+1) + 1;
  localparam int HCW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
  localparam int CCW = $clog2(CLASS_CNT);

  typedef enum logic [1:0] {IDLE, ACC, ARG, DONE} state_t;

  state_t                         r_state, w_state_nxt;
  logic [HIDDEN_CNT-1:0]          r_h;
  logic [HCW-1:0]                 r_hcnt;
  logic [CCW-1:0]                 r_ccnt;
  logic [CCW-1:0]                 r_best_idx;
  logic signed [SW-1:0]           r_best_val;
  logic [CCW-1:0]                 r_class_out;
  logic                           r_done;

  logic [CLASS_CNT-1:0][SW-1:0]   w_score;
  logic [CLASS_CNT-1:0][SW-1:0]   w_score_nxt;
  logic                           w_clr;
  logic                           w_acc;
  logic                           w_acc_last;
  logic                           w_arg_last;
  logic                           w_hbit;
  logic                           w_better;

  assign w_clr      = (r_state == IDLE) && start;
  assign w_acc      = (r_state == ACC);
  assign w_acc_last = (r_hcnt == HCW'(HIDDEN_CNT-1));
  assign w_arg_last = (r_ccnt == CCW'(CLASS_CNT-1));
  assign w_hbit     = r_h[r_hcnt];
  // Strict compare so ties keep the lower index
  assign w_better   = $signed(w_score[r_ccnt]) > r_best_val;

  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
    output_layer_argmax_tnndirect_cls #(
      .HIDDEN_CNT(HIDDEN_CNT), .CLASS_CNT(CLASS_CNT), .C(c),
      .WEIGHTS(WEIGHTS), .MASK(MASK), .SW(SW), .HCW(HCW)
    ) u_cls (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_en       (w_acc),
      .i_hcnt     (r_hcnt),
      .i_h        (w_hbit),
      .o_score    (w_score[c]),
      .o_score_nxt(w_score_nxt[c])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; DONE is terminal until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)      w_state_nxt = ACC;
      ACC:     if (w_acc_last) w_state_nxt = ARG;
      ARG:     if (w_arg_last) w_state_nxt = DONE;
      default: w_state_nxt = DONE;
    endcase
  end

  // Datapath: capture, counters, running argmax and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= '0;
      r_hcnt      <= '0;
      r_ccnt      <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_class_out <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_h    <= hidden;
          r_hcnt <= '0;
        end
        ACC: if (w_acc_last) begin
          // Seed the argmax with class 0's post-update score
          r_best_idx <= '0;
          r_best_val <= $signed(w_score_nxt[0]);
          r_ccnt     <= CCW'(1);
        end else begin
          r_hcnt <= r_hcnt + HCW'(1);
        end
        ARG: begin
          if (w_better) begin
            r_best_idx <= r_ccnt;
            r_best_val <= $signed(w_score[r_ccnt]);
          end
          if (w_arg_last) begin
            r_class_out <= w_better ? r_ccnt : r_best_idx;
            r_done      <= 1'b1;
          end else begin
            r_ccnt <= r_ccnt + CCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign class_out = r_class_out;
  assign done      = r_done;
endmodule

// File: tb/tb_output_layer_argmax_tnndirect.sv
// Bench for output_layer_argmax_tnndirect: three instances sharing stimulus
// (full mask, class0 masked out, all masked) checked against a table of
// hand-derived results and a reference model on random vectors.
module tb_output_layer_argmax_tnndirect;
  localparam int H = 4;
  localparam int C = 3;
  // Bit h*C+c. class0 all +1, class1 all -1, class2 = +1,+1,-1,-1
  localparam logic [H*C-1:0] W_MAIN = 12'b001_001_101_101;
  localparam logic [H*C-1:0] M_ALL  = 12'hFFF;
  localparam logic [H*C-1:0] M_NO0  = 12'b110_110_110_110;
  localparam logic [H*C-1:0] M_NONE = 12'h000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] hidden;
  logic [1:0] co_a, co_b, co_z;
  logic       d_a, d_b, d_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_layer_argmax_tnndirect #(.HIDDEN_CNT(H), .CLASS_CNT(C), .WEIGHTS(W_MAIN), .MASK(M_ALL))
    u_a (.clk(clk), .rst(rst), .start(start), .hidden(hidden), .class_out(co_a), .done(d_a));
  output_layer_argmax_tnndirect #(.HIDDEN_CNT(H), .CLASS_CNT(C), .WEIGHTS(W_MAIN), .MASK(M_NO0))
    u_b (.clk(clk), .rst(rst), .start(start), .hidden(hidden), .class_out(co_b), .done(d_b));
  output_layer_argmax_tnndirect #(.HIDDEN_CNT(H), .CLASS_CNT(C), .WEIGHTS(W_MAIN), .MASK(M_NONE))
    u_z (.clk(clk), .rst(rst), .start(start), .hidden(hidden), .class_out(co_z), .done(d_z));

  typedef struct {
    logic [3:0] h;
    int         ea;
    int         eb;
    int         ez;
  } vec_t;

  // Reference: plain sums per class, then first index with the maximum
  function automatic int model(input logic [H*C-1:0] w, input logic [H*C-1:0] m,
                               input logic [3:0] hv);
    int sc[C];
    int best;
    for (int c = 0; c < C; c++) begin
      sc[c] = 0;
      for (int h = 0; h < H; h++)
        if (m[h*C+c]) sc[c] += (hv[h] == w[h*C+c]) ? 1 : -1;
    end
    best = 0;
    for (int c = 1; c < C; c++) if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reset, present start/hidden, count edges until done (bounded)
  task automatic run(input logic [3:0] hv, input bit tog, input bit drop,
                     output int lat, output bit early);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0; hidden = hv; start = 1'b1;
    lat = 0; early = 1'b0;
    for (int e = 1; e <= 30 && lat == 0; e++) begin
      @(posedge clk); #1;
      if (d_a) lat = e;
      else if (co_a !== 2'd0 || co_b !== 2'd0 || d_b) early = 1'b1;
      if (tog)  hidden = ~hidden;
      if (drop) start = 1'b0;
    end
    start = 1'b0;
  endtask

  vec_t vecs[5];
  int   lat;
  bit   early;

  initial begin
    vecs[0] = '{h: 4'b1111, ea: 0, eb: 0, ez: 0};
    vecs[1] = '{h: 4'b0000, ea: 1, eb: 1, ez: 0};
    vecs[2] = '{h: 4'b0011, ea: 2, eb: 2, ez: 0};
    vecs[3] = '{h: 4'b1100, ea: 0, eb: 0, ez: 0};
    vecs[4] = '{h: 4'b0101, ea: 0, eb: 0, ez: 0};

    rst = 1'b1; start = 1'b0; hidden = 4'b0;
    #12;
    chk("reset_done", {31'b0, d_a}, 0);
    chk("reset_class", {30'b0, co_a}, 0);
    @(negedge clk); rst = 1'b0;

    // Idle with start low: nothing happens
    repeat (20) @(posedge clk);
    #1;
    chk("idle_done", {31'b0, d_a}, 0);
    chk("idle_class", {30'b0, co_a}, 0);

    foreach (vecs[i]) begin
      run(vecs[i].h, 1'b0, 1'b0, lat, early);
      chk($sformatf("vec%0d_latency", i), lat, 7);
      chk($sformatf("vec%0d_early", i), {31'b0, early}, 0);
      chk($sformatf("vec%0d_class_a", i), {30'b0, co_a}, vecs[i].ea);
      chk($sformatf("vec%0d_class_b", i), {30'b0, co_b}, vecs[i].eb);
      chk($sformatf("vec%0d_class_z", i), {30'b0, co_z}, vecs[i].ez);
    end

    // DONE holds regardless of start/hidden
    run(4'b0000, 1'b0, 1'b0, lat, early);
    start = 1'b1; hidden = 4'b0011;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_class", {30'b0, co_a}, 1);
    chk("hold_done", {31'b0, d_a}, 1);
    // Reset in DONE clears outputs without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_done_class", {30'b0, co_a}, 0);
    chk("rst_done_done", {31'b0, d_a}, 0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Reset on the 3rd edge of a run (in ACC) aborts it
    @(negedge clk);
    hidden = 4'b0000; start = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_acc_done", {31'b0, d_a}, 0);
    chk("rst_acc_class", {30'b0, co_a}, 0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_acc_idle_done", {31'b0, d_a}, 0);
    run(4'b1111, 1'b0, 1'b0, lat, early);
    chk("rerun_latency", lat, 7);
    chk("rerun_class", {30'b0, co_a}, 0);

    // Hidden toggling and start dropping after capture are ignored
    run(4'b0011, 1'b1, 1'b1, lat, early);
    chk("toggle_latency", lat, 7);
    chk("toggle_class", {30'b0, co_a}, 2);

    // Random vectors against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [3:0] hv;
      bit tg, dp;
      hv = 4'($urandom_range(0, 15));
      tg = 1'($urandom_range(0, 1));
      dp = 1'($urandom_range(0, 1));
      run(hv, tg, dp, lat, early);
      chk($sformatf("rnd%0d_latency", r), lat, 7);
      chk($sformatf("rnd%0d_class_a", r), {30'b0, co_a}, model(W_MAIN, M_ALL, hv));
      chk($sformatf("rnd%0d_class_b", r), {30'b0, co_b}, model(W_MAIN, M_NO0, hv));
      chk($sformatf("rnd%0d_class_z", r), {30'b0, co_z}, model(W_MAIN, M_NONE, hv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_layer_argmax_tnndirect.md
Name: output_layer_argmax_tnndirect

Overview:
Second (output) layer of the direct ternary network. It sits directly downstream of the first hidden layer and consumes that layer's binary hidden activations once the layer signals done. It serially accumulates one signed score per class using hard-wired ternary weights, then serially selects the highest-scoring class. It presents the class index with a sticky done flag.

Parameters:
HIDDEN_CNT, 4, number of hidden activations consumed (>=1)
CLASS_CNT, 3, number of output classes (>=2)
WEIGHTS, 0, [HIDDEN_CNT*CLASS_CNT-1:0] sign of each nonzero weight, bit h*CLASS_CNT+c (1 = +1, 0 = -1)
MASK, 0, [HIDDEN_CNT*CLASS_CNT-1:0] same layout; 1 = weight nonzero, 0 = weight is zero
SW, $clog2(HIDDEN_CNT+1)+1, signed score width (derived; not to be overridden)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  level; tied to upstream layer done; high = hidden valid and stable
hidden  input  HIDDEN_CNT  binary activations; bit=1 means +1, bit=0 means -1
class_out  output  $clog2(CLASS_CNT)  index of winning class
done  output  1  high once class_out is valid; sticky until rst

Behaviour:
- Reset (async, rst=1): state=IDLE; hcnt, ccnt, scores, best_idx, best_val cleared; class_out=0; done=0.
- FSM states: IDLE, ACC, ARG, DONE.
- IDLE: if start=1 at a clock edge, capture hidden into an internal register, clear all CLASS_CNT scores, hcnt=0, go to ACC. If start=0, stay in IDLE with no state change.
- ACC, one hidden index per cycle, hcnt = 0..HIDDEN_CNT-1. For every class c, with k = hcnt*CLASS_CNT+c:
  - contribution = 0 if MASK[k]=0;
  - otherwise +1 if h_reg[hcnt] XNOR WEIGHTS[k], else -1.
  - score[c] += contribution, SW-bit signed. Overflow is impossible since |score| <= HIDDEN_CNT.
  - Leaving ACC: on the edge where hcnt=HIDDEN_CNT-1, go to ARG with best_idx=0, best_val=score[0] (post-update value), ccnt=1.
- ARG, one class per cycle, ccnt = 1..CLASS_CNT-1:
  - if score[ccnt] > best_val (signed, strict), best_idx=ccnt and best_val=score[ccnt].
  - Ties keep the lower index.
  - On the edge processing ccnt=CLASS_CNT-1, load class_out with the final best_idx (including that comparison), set done=1, go to DONE.
- DONE: hold class_out and done. start and hidden are ignored. Leave only via rst.
- Latency: done rises on the (HIDDEN_CNT+CLASS_CNT)-th rising edge counting the edge that samples start=1 as edge 1. Defaults give 7 edges.
- class_out stays 0 until DONE; no intermediate values are visible.
- hidden changing after capture has no effect.
- start falling during ACC/ARG has no effect; the run completes.
- rst mid-operation (any state): immediate return to the reset condition. A fresh run begins at the first edge after rst deasserts where start=1.
- Counters sized $clog2 of the range with a minimum of 1 bit. Counters never wrap: each exits at its terminal value.

Test Plan:
(Defaults HIDDEN_CNT=4, CLASS_CNT=3, MASK all 1. WEIGHTS: class0 all +1, class1 all -1, class2 = +1,+1,-1,-1 for h0..h3.)
1. start=1, hidden=4'b1111 -> scores (4,-4,0); class_out=0; done high exactly 7 edges after start sampled.
2. hidden=4'b0000 -> scores (-4,4,0); class_out=1, done=1.
3. hidden=4'b0011 (h0=h1=1) -> scores (0,0,4); class_out=2.
4. MASK all 0, any hidden -> all scores 0, tie; class_out=0. With MASK clearing class0 only and hidden=4'b0000 -> (0,4,0), class_out=1.
5. start held 0 for 20 cycles -> done=0, class_out=0. Then start=1, and hidden toggled every cycle after capture -> result matches the captured value only.
6. rst pulsed during ACC (3rd cycle) -> done=0, class_out=0 immediately. Rerun with hidden=4'b1111 -> class_out=0 after 7 edges. rst in DONE -> outputs cleared asynchronously.
